apb_rr_sched: RTL and testbench

//  Shares one APB master port among NUM_REQ requesters (e.g. AXI2APB bridge instances, debug/config masters).

---
 rtl/apb_rr_sched_pkg.sv | 24 ++
 rtl/rr_grant.sv | 30 +++
 rtl/apb_rr_sched.sv | 155 +++++++++++++++
 tb/tb_apb_rr_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_rr_sched_pkg.sv
// Shared types and constants for the APB round-robin scheduler.
// apb_req_t is the default-width request view; the top keeps a parameter-sized copy.
package apb_rr_sched_pkg;

  localparam int APB_PROT_W = 3;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 16;
  localparam int APB_STRB_W = APB_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } sched_state_t;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
    logic                  write;
    logic [APB_PROT_W-1:0] prot;
  } apb_req_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_grant #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/apb_rr_sched.sv
// Shares one APB master port among NUM_REQ requesters with round-robin grant,
// SETUP/ACCESS sequencing and a PREADY timeout that completes with an error.
import apb_rr_sched_pkg::*;

module apb_rr_sched #(
  parameter int NUM_REQ         = 4,
  parameter int APB_addr_length = APB_ADDR_W,
  parameter int APB_data_length = APB_DATA_W,
  parameter int APB_strb_length = APB_STRB_W,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*APB_addr_length-1:0]   req_addr,
  input  logic [NUM_REQ*APB_data_length-1:0]   req_wdata,
  input  logic [NUM_REQ*APB_strb_length-1:0]   req_strb,
  input  logic [NUM_REQ-1:0]                   req_write,
  input  logic [NUM_REQ*APB_PROT_W-1:0]        req_prot,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [APB_data_length-1:0]           rsp_rdata,
  output logic                                 rsp_slverr,
  output logic                                 rsp_timeout,
  output logic [APB_addr_length-1:0]           PADDR,
  output logic [APB_PROT_W-1:0]                PPROT,
  output logic [APB_strb_length-1:0]           PSTRB,
  output logic                                 PSEL,
  output logic                                 PENABLE,
  output logic [APB_data_length-1:0]           PWDATA,
  output logic                                 PWRITE,
  input  logic [APB_data_length-1:0]           PRDATA,
  input  logic                                 PREADY,
  input  logic                                 PSLVERR
);

  localparam int IW     = $clog2(NUM_REQ);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam int CW     = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef struct packed {
    logic [APB_addr_length-1:0] addr;
    logic [APB_data_length-1:0] wdata;
    logic [APB_strb_length-1:0] strb;
    logic                       write;
    logic [APB_PROT_W-1:0]      prot;
  } req_t;

  sched_state_t               state_q;
  req_t                       req_q;
  req_t                       req_d;
  logic [IW-1:0]              ptr_q;
  logic [IW-1:0]              ptr_nxt;
  logic [IW-1:0]              idx_q;
  logic [CW-1:0]              cnt_q;
  logic                       psel_q;
  logic                       penable_q;
  logic [NUM_REQ-1:0]         rsp_valid_q;
  logic [APB_data_length-1:0] rsp_rdata_q;
  logic                       rsp_slverr_q;
  logic                       rsp_timeout_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               grant;
  logic               acc_done;
  logic               acc_tmo;

  rr_grant #(.N(NUM_REQ)) u_rr_grant (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign grant     = (state_q == ST_IDLE) && gnt_any;
  assign req_ready = (rst_n && state_q == ST_IDLE) ? gnt : '0;
  assign ptr_nxt   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  // Read transfers drive zero write data and strobes onto the bus.
  always_comb begin
    req_d.addr  = req_addr[int'(gnt_idx)*APB_addr_length +: APB_addr_length];
    req_d.write = req_write[gnt_idx];
    req_d.prot  = req_prot[int'(gnt_idx)*APB_PROT_W +: APB_PROT_W];
    req_d.wdata = req_write[gnt_idx] ? req_wdata[int'(gnt_idx)*APB_data_length +: APB_data_length] : '0;
    req_d.strb  = req_write[gnt_idx] ? req_strb[int'(gnt_idx)*APB_strb_length +: APB_strb_length] : '0;
  end

  // PREADY takes priority over the timeout on the last allowed wait cycle.
  assign acc_done = (state_q == ST_ACCESS) && PREADY;
  assign acc_tmo  = (state_q == ST_ACCESS) && !PREADY && TMO_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      ptr_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            req_q   <= req_d;
            idx_q   <= gnt_idx;
            ptr_q   <= ptr_nxt;
            psel_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (acc_done || acc_tmo) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= NUM_REQ'(1) << idx_q;
            rsp_slverr_q  <= acc_tmo ? 1'b1 : PSLVERR;
            rsp_timeout_q <= acc_tmo;
            rsp_rdata_q   <= (acc_done && !req_q.write) ? PRDATA : '0;
            state_q       <= ST_IDLE;
          end
          if (!PREADY) cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PADDR       = req_q.addr;
  assign PWDATA      = req_q.wdata;
  assign PSTRB       = req_q.strb;
  assign PWRITE      = req_q.write;
  assign PPROT       = req_q.prot;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_rr_sched.sv
// Directed bench for apb_rr_sched with a transaction-level reference model and APB slave responder.
module tb_apb_rr_sched;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int SW  = 2;
  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*SW-1:0]   req_strb;
  logic [N-1:0]      req_write;
  logic [N*3-1:0]    req_prot;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;
  logic [AW-1:0]     PADDR;
  logic [2:0]        PPROT;
  logic [SW-1:0]     PSTRB;
  logic              PSEL;
  logic              PENABLE;
  logic [DW-1:0]     PWDATA;
  logic              PWRITE;
  logic [DW-1:0]     PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  apb_rr_sched #(
    .NUM_REQ(N), .APB_addr_length(AW), .APB_data_length(DW),
    .APB_strb_length(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_write(req_write), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PPROT(PPROT), .PSTRB(PSTRB), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PWRITE(PWRITE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // requester side
  int            pend [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wdata [N];
  logic [SW-1:0] p_strb [N];
  logic          p_write [N];
  logic [2:0]    p_prot [N];
  logic [N-1:0]  took;

  // slave behaviour for the next transfer
  int        cfg_waits;
  logic [DW-1:0] cfg_rdata;
  logic      cfg_err;
  int        acc_k;

  // reference model: transfer occupies setup + n access cycles after the grant cycle
  bit            m_busy;
  int            m_ptr, m_g, m_gcyc, m_n, m_rsp_cyc;
  bit            m_tmo;
  logic [DW-1:0] m_rd;
  logic          m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_strb;
  logic          m_write;
  logic [2:0]    m_prot;
  logic [N-1:0]  m_rsp_vec;
  logic [DW-1:0] m_rsp_rdata;
  logic          m_rsp_err, m_rsp_tmo;

  // observations of the DUT for the literal checks
  int            gnt_log[$];
  int            last_acc_len, psel_rise, pen_rise, obs_rsp_cyc;
  logic          prev_psel, prev_pen;
  logic [N-1:0]  obs_vec;
  logic [DW-1:0] obs_rdata;
  logic          obs_err, obs_tmo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_g = 0; m_gcyc = 0; m_n = 0; m_tmo = 0; m_rsp_cyc = -1;
    m_rd = '0; m_err = 0; m_addr = '0; m_wdata = '0; m_strb = '0; m_write = 0; m_prot = '0;
    m_rsp_vec = '0; m_rsp_rdata = '0; m_rsp_err = 0; m_rsp_tmo = 0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic w, input logic [2:0] p);
    p_addr[i] = a; p_wdata[i] = d; p_strb[i] = s; p_write[i] = w; p_prot[i] = p;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW] = s;
    req_write[i] = w;
    req_prot[i*3 +: 3] = p;
  endtask

  // One clock cycle: apply requests, respond as slave, compare against the model, advance.
  task automatic tick();
    int g, j, d;
    logic [N-1:0] e_ready;
    logic e_psel, e_pen;
    for (int i = 0; i < N; i++) req_valid[i] = (pend[i] > 0);
    @(negedge clk);
    if (PSEL && PENABLE) begin
      PREADY  = (acc_k == cfg_waits);
      PSLVERR = PREADY ? cfg_err : 1'b0;
      PRDATA  = PREADY ? cfg_rdata : 16'h0BAD;
      acc_k++;
    end else begin
      if (acc_k > 0) last_acc_len = acc_k;
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 16'h0BAD; acc_k = 0;
    end

    if (m_busy && cyc == m_gcyc + m_n + 2) begin
      m_busy      = 0;
      m_rsp_cyc   = cyc;
      m_rsp_vec   = '0;
      m_rsp_vec[m_g] = 1'b1;
      m_rsp_err   = m_tmo ? 1'b1 : m_err;
      m_rsp_tmo   = m_tmo;
      m_rsp_rdata = (m_tmo || m_write) ? '0 : m_rd;
    end
    d      = cyc - m_gcyc;
    e_psel = m_busy && d >= 1;
    e_pen  = m_busy && d >= 2;
    g = -1;
    if (rst_n && !m_busy)
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;

    chk("req_ready", req_ready, e_ready);
    chk("psel", PSEL, e_psel);
    chk("penable", PENABLE, e_pen);
    chk("rsp_valid", rsp_valid, (cyc == m_rsp_cyc) ? m_rsp_vec : '0);
    chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
    chk("rsp_err_tmo", {rsp_slverr, rsp_timeout}, {m_rsp_err, m_rsp_tmo});
    chk("apb_bus", {PADDR, PWDATA, PSTRB, PWRITE, PPROT}, {m_addr, m_wdata, m_strb, m_write, m_prot});

    for (int i = 0; i < N; i++) if (req_ready[i]) gnt_log.push_back(i);
    if (PSEL && !prev_psel) psel_rise = cyc;
    if (PENABLE && !prev_pen) pen_rise = cyc;
    prev_psel = PSEL; prev_pen = PENABLE;
    if (rsp_valid != '0) begin
      obs_rsp_cyc = cyc; obs_vec = rsp_valid; obs_rdata = rsp_rdata;
      obs_err = rsp_slverr; obs_tmo = rsp_timeout;
    end

    if (!rst_n) model_reset();
    else if (g >= 0) begin
      m_busy = 1; m_gcyc = cyc; m_g = g; m_ptr = (g + 1) % N;
      m_addr = p_addr[g]; m_write = p_write[g]; m_prot = p_prot[g];
      m_wdata = p_write[g] ? p_wdata[g] : '0;
      m_strb  = p_write[g] ? p_strb[g] : '0;
      m_n   = (cfg_waits < TMO) ? cfg_waits + 1 : TMO;
      m_tmo = (cfg_waits >= TMO);
      m_rd = cfg_rdata; m_err = cfg_err;
      took[g] = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (took[i]) pend[i]--;
    took = '0;
  endtask

  task automatic run_idle(input int budget);
    int left;
    bit pending;
    left = budget;
    pending = 1;
    while (pending && left > 0) begin
      tick();
      left--;
      pending = m_busy || (cyc <= m_rsp_cyc);
      for (int i = 0; i < N; i++) if (pend[i] > 0) pending = 1;
    end
    chk("run_budget", pending, 1'b0);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
    req_write = '0; req_prot = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    took = '0; acc_k = 0; cfg_waits = 0; cfg_rdata = '0; cfg_err = 1'b0;
    last_acc_len = 0; psel_rise = -1; pen_rise = -1; obs_rsp_cyc = -1;
    prev_psel = 0; prev_pen = 0; obs_vec = '0; obs_rdata = '0; obs_err = 0; obs_tmo = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; set_req(i, '0, '0, '0, 1'b0, '0); end
    model_reset();

    tick(); tick();
    chk("reset_psel_pen", {PSEL, PENABLE}, 2'b00);
    chk("reset_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, '0);
    chk("reset_paddr", PADDR, 32'h0);
    rst_n = 1'b1;

    // single read from requester 0
    cfg_waits = 0; cfg_rdata = 16'hBEEF; cfg_err = 1'b0;
    set_req(0, 32'h100, 16'h1111, 2'b11, 1'b0, 3'b010);
    pend[0] = 1;
    t0 = cyc;
    run_idle(20);
    chk("rd0_psel_cycle", psel_rise - t0, 1);
    chk("rd0_penable_cycle", pen_rise - t0, 2);
    chk("rd0_rsp_cycle", obs_rsp_cyc - t0, 3);
    chk("rd0_rsp_vec", obs_vec, 4'b0001);
    chk("rd0_rdata", obs_rdata, 16'hBEEF);

    // pointer back to 0, then all four requesters ask for two transfers each
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    cfg_rdata = 16'h5A5A;
    set_req(0, 32'h1000, 16'hA0A0, 2'b01, 1'b1, 3'b000);
    set_req(1, 32'h2004, 16'hB1B1, 2'b10, 1'b0, 3'b001);
    set_req(2, 32'h3008, 16'hC2C2, 2'b11, 1'b1, 3'b100);
    set_req(3, 32'h400C, 16'hD3D3, 2'b11, 1'b0, 3'b111);
    gnt_log.delete();
    for (int i = 0; i < N; i++) pend[i] = 2;
    run_idle(80);
    chk("rr_grant_count", gnt_log.size(), 8);
    for (int k = 0; k < 8; k++)
      chk("rr_grant_order", (k < gnt_log.size()) ? gnt_log[k] : -1, k % 4);

    // write from requester 2 with PSLVERR after three wait states
    cfg_waits = 3; cfg_err = 1'b1;
    set_req(2, 32'h40, 16'hCAFE, 2'b11, 1'b1, 3'b000);
    pend[2] = 1;
    run_idle(20);
    chk("wr2_access_len", last_acc_len, 4);
    chk("wr2_rsp", {obs_vec, obs_err, obs_tmo}, {4'b0100, 1'b1, 1'b0});
    chk("wr2_rdata", obs_rdata, 16'h0);

    // PREADY never arrives: timeout after four ACCESS cycles
    cfg_waits = 1000; cfg_err = 1'b0;
    set_req(1, 32'h80, 16'h0, 2'b00, 1'b0, 3'b000);
    pend[1] = 1;
    run_idle(20);
    chk("tmo_access_len", last_acc_len, 4);
    chk("tmo_rsp", {obs_vec, obs_err, obs_tmo}, {4'b0010, 1'b1, 1'b1});

    // PREADY on the fourth wait cycle wins over the timeout
    cfg_waits = 3; cfg_rdata = 16'h1234; cfg_err = 1'b0;
    set_req(3, 32'hC0, 16'h0, 2'b00, 1'b0, 3'b000);
    pend[3] = 1;
    run_idle(20);
    chk("edge_access_len", last_acc_len, 4);
    chk("edge_rsp", {obs_vec, obs_err, obs_tmo}, {4'b1000, 1'b0, 1'b0});
    chk("edge_rdata", obs_rdata, 16'h1234);

    // reset during ACCESS of a read from requester 1
    cfg_waits = 1000;
    set_req(1, 32'hABC0, 16'h0, 2'b00, 1'b0, 3'b011);
    pend[1] = 1;
    obs_rsp_cyc = -1;
    tick(); tick();
    chk("rst_mid_in_access", {PSEL, PENABLE}, 2'b11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_apb_zero", {PSEL, PENABLE, PADDR, PPROT}, '0);
    chk("rst_mid_rsp_zero", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}, '0);
    cfg_waits = 0; cfg_rdata = 16'h7777;
    set_req(3, 32'hD00, 16'h0, 2'b00, 1'b0, 3'b000);
    gnt_log.delete();
    pend[1] = 1; pend[3] = 1;
    run_idle(30);
    chk("rst_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
    chk("rst_second_grant", (gnt_log.size() > 1) ? gnt_log[1] : -1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
